// File: rtl/oam_dma_pkg.sv
// Shared types and bus addresses for the NES sprite DMA sequencer.
// The register addresses are also used by the PPU and the address decoder.
package oam_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to the DMA register, stalls the CPU and copies
// one 256-byte page to the OAM data port as alternating read/write bus cycles.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int unsigned          ADDR_N   = 16,
    parameter int unsigned          DATA_N   = 8,
    parameter logic [ADDR_N-1:0]    DMA_REG  = DMA_REG_ADDR,
    parameter logic [ADDR_N-1:0]    OAM_DATA = OAM_DATA_ADDR
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_N-1:0] cpu_addr_i,
    input  logic [DATA_N-1:0] cpu_wdata_i,
    input  logic              cpu_we_i,
    output logic              cpu_rdy_o,
    output logic [ADDR_N-1:0] bus_addr_o,
    output logic [DATA_N-1:0] bus_wdata_o,
    output logic              bus_we_o,
    input  logic [DATA_N-1:0] bus_rdata_i,
    output logic              dma_busy_o
);

    dma_state_t        state_q, state_d;
    logic [DATA_N-1:0] page_q, page_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_N-1:0] buf_q, buf_d;
    logic              parity_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            page_q   <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            parity_q <= ~parity_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        cpu_rdy_o   = 1'b0;
        bus_addr_o  = cpu_addr_i;
        bus_wdata_o = cpu_wdata_i;
        bus_we_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cpu_rdy_o = 1'b1;
                bus_we_o  = cpu_we_i;
                if (cpu_we_i && (cpu_addr_i == DMA_REG)) begin
                    page_d  = cpu_wdata_i;
                    cnt_d   = '0;
                    state_d = HALT;
                end
            end
            // An odd-parity HALT goes straight to READ so reads stay on even cycles.
            HALT:  state_d = parity_q ? READ : ALIGN;
            ALIGN: state_d = READ;
            READ: begin
                bus_addr_o = ADDR_N'({page_q, cnt_q});
                buf_d      = bus_rdata_i;
                state_d    = WRITE;
            end
            WRITE: begin
                bus_addr_o  = OAM_DATA;
                bus_wdata_o = buf_q;
                bus_we_o    = 1'b1;
                cnt_d       = cnt_q + 8'd1;
                state_d     = (cnt_q == 8'hff) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dma_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a byte-array memory answers bus reads and every
// write to the OAM data port is logged for comparison after each transfer.
module tb_oam_dma;
    import oam_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic [7:0]  bus_rdata;
    logic        dma_busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] wr_data [0:511];
    int         wr_cnt = 0;
    logic       tb_par;

    oam_dma #(.ADDR_N(16), .DATA_N(8), .DMA_REG(16'h4014), .OAM_DATA(16'h2004)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cpu_addr_i (cpu_addr),
        .cpu_wdata_i(cpu_wdata),
        .cpu_we_i   (cpu_we),
        .cpu_rdy_o  (cpu_rdy),
        .bus_addr_o (bus_addr),
        .bus_wdata_o(bus_wdata),
        .bus_we_o   (bus_we),
        .bus_rdata_i(bus_rdata),
        .dma_busy_o (dma_busy)
    );

    always #5 clk = ~clk;

    assign bus_rdata = mem[bus_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    always @(posedge clk) begin
        if (!rst && bus_we && bus_addr == 16'h2004) begin
            if (wr_cnt < 512) wr_data[wr_cnt] = bus_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    // Trigger a DMA from the IDLE cycle whose parity matches par; returns at the
    // negedge of the first halted cycle with the CPU inputs released.
    task automatic start_dma(input logic [7:0] page, input logic par);
        if (tb_par !== par) @(negedge clk);
        cpu_addr  = 16'h4014;
        cpu_wdata = page;
        cpu_we    = 1'b1;
        @(negedge clk);
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
    endtask

    // Count halted cycles from the current negedge until cpu_rdy returns (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (cpu_rdy === 1'b0 && n < 700) begin
            n = n + 1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        tests++; if (cpu_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy got %b want 1", cpu_rdy); end
        tests++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", dma_busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cpu_addr = 16'h0010; cpu_wdata = 8'h55; cpu_we = 1'b1;
        #1;
        tests++; if (bus_addr !== 16'h0010 || bus_wdata !== 8'h55 || bus_we !== 1'b1) begin
            fails++; $display("FAIL passthrough got %h/%h/%b want 0010/55/1", bus_addr, bus_wdata, bus_we);
        end
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_align;
        int n;
        wr_cnt = 0;
        if (tb_par !== 1'b1) @(negedge clk);
        cpu_addr = 16'h4014; cpu_wdata = 8'h02; cpu_we = 1'b1;
        #1;
        tests++; if (bus_we !== 1'b1 || bus_addr !== 16'h4014) begin
            fails++; $display("FAIL trigger_fwd got %h/%b want 4014/1", bus_addr, bus_we);
        end
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 16'h1234;
        #1;
        tests++; if (cpu_rdy !== 1'b0 || dma_busy !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 16'h1234 || tb_par !== 1'b0) begin
            fails++; $display("FAIL halt_odd got rdy=%b busy=%b we=%b addr=%h par=%b want 0/1/0/1234/0", cpu_rdy, dma_busy, bus_we, bus_addr, tb_par);
        end
        @(negedge clk);
        tests++; if (cpu_rdy !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 16'h1234) begin
            fails++; $display("FAIL align got rdy=%b we=%b addr=%h want 0/0/1234", cpu_rdy, bus_we, bus_addr);
        end
        cpu_addr = 16'h0000;
        @(negedge clk);
        tests++; if (bus_addr !== 16'h0200 || bus_we !== 1'b0 || tb_par !== 1'b0) begin
            fails++; $display("FAIL first_read_align got addr=%h we=%b par=%b want 0200/0/0", bus_addr, bus_we, tb_par);
        end
        wait_idle(n);
        tests++; if (n + 2 !== 514) begin fails++; $display("FAIL halt_len_align got %0d want 514", n + 2); end
        tests++; if (dma_busy !== 1'b0 || wr_cnt !== 256) begin
            fails++; $display("FAIL align_done got busy=%b writes=%0d want 0/256", dma_busy, wr_cnt);
        end
    endtask

    task automatic test_no_align;
        int n;
        wr_cnt = 0;
        start_dma(8'h02, 1'b0);
        tests++; if (cpu_rdy !== 1'b0 || tb_par !== 1'b1) begin
            fails++; $display("FAIL halt_even got rdy=%b par=%b want 0/1", cpu_rdy, tb_par);
        end
        @(negedge clk);
        tests++; if (bus_addr !== 16'h0200 || bus_we !== 1'b0 || tb_par !== 1'b0) begin
            fails++; $display("FAIL first_read_noalign got addr=%h we=%b par=%b want 0200/0/0", bus_addr, bus_we, tb_par);
        end
        @(negedge clk);
        tests++; if (bus_addr !== 16'h2004 || bus_we !== 1'b1 || bus_wdata !== 8'h03) begin
            fails++; $display("FAIL first_write got addr=%h we=%b data=%h want 2004/1/03", bus_addr, bus_we, bus_wdata);
        end
        wait_idle(n);
        tests++; if (n + 2 !== 513) begin fails++; $display("FAIL halt_len_noalign got %0d want 513", n + 2); end
    endtask

    task automatic test_data_order;
        int n, bad;
        wr_cnt = 0;
        start_dma(8'h03, 1'b1);
        wait_idle(n);
        tests++; if (wr_cnt !== 256) begin fails++; $display("FAIL page3_count got %0d want 256", wr_cnt); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (wr_data[i] !== (8'(i) ^ 8'hA5)) bad++;
        tests++; if (bad !== 0) begin fails++; $display("FAIL page3_data got %0d wrong bytes want 0", bad); end
        tests++; if (wr_data[0] !== 8'hA5 || wr_data[1] !== 8'hA4 || wr_data[255] !== 8'h5A) begin
            fails++; $display("FAIL page3_ends got %h %h %h want a5 a4 5a", wr_data[0], wr_data[1], wr_data[255]);
        end
    endtask

    task automatic test_page_ff;
        int n;
        wr_cnt = 0;
        start_dma(8'hFF, 1'b0);
        wait_idle(n);
        tests++; if (wr_cnt !== 256) begin fails++; $display("FAIL pageff_count got %0d want 256", wr_cnt); end
        tests++; if (wr_data[252] !== 8'h00 || wr_data[253] !== 8'hFF || wr_data[0] !== 8'h00 || wr_data[16] !== 8'h10) begin
            fails++; $display("FAIL pageff_vector got %h %h %h %h want 00 ff 00 10", wr_data[252], wr_data[253], wr_data[0], wr_data[16]);
        end
    endtask

    task automatic test_busy_write;
        int n, leaked;
        wr_cnt = 0;
        leaked = 0;
        start_dma(8'h03, 1'b0);
        repeat (10) @(negedge clk);
        cpu_addr = 16'h4014; cpu_wdata = 8'h07; cpu_we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus_we === 1'b1 && bus_addr !== 16'h2004) leaked++;
            @(negedge clk);
        end
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        tests++; if (leaked !== 0) begin fails++; $display("FAIL busy_fwd got %0d forwarded cycles want 0", leaked); end
        wait_idle(n);
        tests++; if (wr_cnt !== 256) begin fails++; $display("FAIL busy_count got %0d want 256", wr_cnt); end
        tests++; if (wr_data[200] !== (8'd200 ^ 8'hA5) || wr_data[255] !== 8'h5A) begin
            fails++; $display("FAIL busy_page got %h %h want %h 5a", wr_data[200], wr_data[255], 8'd200 ^ 8'hA5);
        end
    endtask

    task automatic test_reset_abort;
        int n, t;
        wr_cnt = 0;
        start_dma(8'h03, 1'b1);
        t = 0;
        while (wr_cnt < 100 && t < 700) begin t++; @(negedge clk); end
        rst = 1'b1;
        #1;
        tests++; if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || bus_we !== 1'b0) begin
            fails++; $display("FAIL abort_now got rdy=%b busy=%b we=%b want 1/0/0", cpu_rdy, dma_busy, bus_we);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        tests++; if (wr_cnt !== 100) begin fails++; $display("FAIL abort_writes got %0d want 100", wr_cnt); end
        wr_cnt = 0;
        start_dma(8'h02, 1'b0);
        wait_idle(n);
        tests++; if (wr_cnt !== 256 || wr_data[0] !== 8'h03 || wr_data[255] !== 8'h02) begin
            fails++; $display("FAIL restart got writes=%0d first=%h last=%h want 256/03/02", wr_cnt, wr_data[0], wr_data[255]);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i + 3);
            mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
        end
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'hFF;

        test_reset;
        test_align;
        test_no_align;
        test_data_order;
        test_page_ff;
        test_busy_write;
        test_reset_abort;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
